an_corrector_n29: RTL and testbench
===================================

# an_corrector_n29

Single-error-correcting back end for the A=29 AN-code datapath. It sits directly downstream of the Barrett-reduction decoder and consumes its per-word result: quotient q, residue r, error flag and the received 14-bit codeword. For A=29 and 14-bit codewords, every nonzero residue 1..28 maps to exactly one single-bit arithmetic error ±2^i, i=0..13, so each word is classified as clean, corrected or uncorrectable. The block is a 2-stage valid/ready pipeline with optional saturating error statistics.

## Interface
- CNT_W, 16, width of each statistics counter.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block accepts the word this cycle.
- in_q  in  10  Barrett quotient.
- in_r  in  5  Barrett residue, 0..28.
- in_error  in  1  upstream error flag; must equal (in_r != 0).
- in_receive  in  14  received codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  10  corrected data word.
- out_codeword  out  14  corrected codeword.
- out_status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 never driven.
- out_bitpos  out  4  error bit index i; 0 when not corrected.
- out_sign  out  1  1 = received was original+2^i, 0 = original−2^i; 0 when not corrected.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_corrected  out  CNT_W  count of corrected words.
- cnt_uncorr  out  CNT_W  count of uncorrectable words.

## Operation
- Syndrome LUT, indexed by in_r. For m = 2^i mod 29 = {1,2,4,8,16,3,6,12,24,19,9,18,7,14} (i=0..13): r=m gives sign=1 and bit i; r=29−m gives sign=0 and bit i. Also output k = floor(2^i/29).
- r=0 and in_error=0: clean. out_data=in_q, out_codeword=in_receive.
- sign=1: codeword = receive − 2^i; data = q − k.
- sign=0: codeword = receive + 2^i; data = q + k + 1.
- Do the codeword arithmetic at 15 bits signed. A result below 0 or above 16383 is uncorrectable.
- in_error disagreeing with (in_r != 0), or in_r > 28, is uncorrectable.
- Uncorrectable results: out_data=in_q, out_codeword=in_receive, bitpos=0, sign=0.
- Stage 1 registers the LUT outputs plus q, r and receive. Stage 2 registers the corrected outputs and status.
- Counters increment when a result is accepted (out_valid & out_ready), by status. They saturate at all-ones.
- cnt_clr has priority over an increment in the same cycle.

## Timing
- Reset values: out_valid=0, both stage valids=0, all data outputs 0, out_status=00, counters 0.
- in_ready is 1 in the cycle after reset.
- Latency: a word accepted in cycle t appears on out_valid in cycle t+2 when there are no stalls. Throughput is one word per cycle.
- Stage 2 loads when s1_valid & (!out_valid | out_ready).
- in_ready = !s1_valid | stage-2 load. This is a combinational path from out_ready.
- Held outputs stay stable while out_valid & !out_ready.
- Once out_valid is asserted, it stays asserted until accepted.
- Reset mid-stream drops all in-flight words and leaves the counters at 0.

## Configuration
- AN_CORR_STATS_EN defined: the counters and cnt_clr logic are present.
- AN_CORR_STATS_EN undefined: the counters are removed, cnt_* outputs are tied to 0 and cnt_clr is ignored.
- Datapath behaviour is identical either way.

## Structure
- Package an29_pkg holds:
  - constants A=29, CW_W=14, DATA_W=10, R_W=5, MAX_CW=16383;
  - the status typedef (CLEAN, CORRECTED, UNCORR);
  - the syndrome-entry struct {valid, sign, bitpos, k}.
- Sub-module an29_syndrome_lut: a purely combinational mapping from r[4:0] to a syndrome entry. It is instantiated in stage 1.

## Test plan
- Clean word: q=100, r=0, err=0, receive=2900 → data 100, codeword 2900, status 00, after 2 cycles.
- Positive error: q=100, r=16, err=1, receive=2916 → bitpos 4, sign 1, codeword 2900, data 100, status 01, cnt_corrected=1.
- Negative error: q=82, r=10, err=1, receive=2388 → bitpos 9, sign 0, codeword 2900, data 100, status 01.
- Range faults:
  - q=564, r=27, receive=16383 → 16385 overflow, status 10.
  - q=0, r=3, receive=3 → underflow, status 10.
  - r=5, err=0 → status 10.
- Backpressure: stream 8 words with out_ready low for 3 cycles mid-stream → no loss or duplication, order preserved, outputs held stable; then one word per cycle again.
- Counter and reset behaviour:
  - Force cnt_uncorr to all-ones → stays saturated.
  - cnt_clr together with an accepted uncorrectable word → counter reads 0.
  - rst asserted with 2 words in flight → out_valid=0 next cycle; counters and outputs are 0.

Source files
------------

// File: rtl/an29_pkg.sv
// Shared constants, status encoding and syndrome-entry type for the A=29 AN-code
// corrector. Used by an29_syndrome_lut and an_corrector_n29.
package an29_pkg;
   localparam int A      = 29;
   localparam int CW_W   = 14;
   localparam int DATA_W = 10;
   localparam int R_W    = 5;
   localparam int BP_W   = 4;
   localparam int MAX_CW = 16383;

   typedef enum logic [1:0] {
      CLEAN     = 2'b00,
      CORRECTED = 2'b01,
      UNCORR    = 2'b10
   } status_e;

   typedef struct packed {
      logic              valid;
      logic              sign;
      logic [BP_W-1:0]   bitpos;
      logic [DATA_W-1:0] k;
   } syn_entry_t;
endpackage

// File: rtl/an29_syndrome_lut.sv
// Combinational map from a nonzero residue to the single-bit error +/-2^i that
// produces it, plus k = floor(2^i/29) for the quotient fix-up.
module an29_syndrome_lut
   import an29_pkg::*;
(
   input  logic [R_W-1:0] r_i,
   output syn_entry_t     entry_o
);

   function automatic syn_entry_t ent(input logic s, input logic [BP_W-1:0] b,
                                      input logic [DATA_W-1:0] kv);
      syn_entry_t e;
      e.valid  = 1'b1;
      e.sign   = s;
      e.bitpos = b;
      e.k      = kv;
      return e;
   endfunction

   // r = 2^i mod 29 means received = original + 2^i; r = 29 - that means original - 2^i
   always_comb begin
      entry_o = '0;
      case (r_i)
         5'd1:  entry_o = ent(1'b1, 4'd0,  10'd0);
         5'd28: entry_o = ent(1'b0, 4'd0,  10'd0);
         5'd2:  entry_o = ent(1'b1, 4'd1,  10'd0);
         5'd27: entry_o = ent(1'b0, 4'd1,  10'd0);
         5'd4:  entry_o = ent(1'b1, 4'd2,  10'd0);
         5'd25: entry_o = ent(1'b0, 4'd2,  10'd0);
         5'd8:  entry_o = ent(1'b1, 4'd3,  10'd0);
         5'd21: entry_o = ent(1'b0, 4'd3,  10'd0);
         5'd16: entry_o = ent(1'b1, 4'd4,  10'd0);
         5'd13: entry_o = ent(1'b0, 4'd4,  10'd0);
         5'd3:  entry_o = ent(1'b1, 4'd5,  10'd1);
         5'd26: entry_o = ent(1'b0, 4'd5,  10'd1);
         5'd6:  entry_o = ent(1'b1, 4'd6,  10'd2);
         5'd23: entry_o = ent(1'b0, 4'd6,  10'd2);
         5'd12: entry_o = ent(1'b1, 4'd7,  10'd4);
         5'd17: entry_o = ent(1'b0, 4'd7,  10'd4);
         5'd24: entry_o = ent(1'b1, 4'd8,  10'd8);
         5'd5:  entry_o = ent(1'b0, 4'd8,  10'd8);
         5'd19: entry_o = ent(1'b1, 4'd9,  10'd17);
         5'd10: entry_o = ent(1'b0, 4'd9,  10'd17);
         5'd9:  entry_o = ent(1'b1, 4'd10, 10'd35);
         5'd20: entry_o = ent(1'b0, 4'd10, 10'd35);
         5'd18: entry_o = ent(1'b1, 4'd11, 10'd70);
         5'd11: entry_o = ent(1'b0, 4'd11, 10'd70);
         5'd7:  entry_o = ent(1'b1, 4'd12, 10'd141);
         5'd22: entry_o = ent(1'b0, 4'd12, 10'd141);
         5'd14: entry_o = ent(1'b1, 4'd13, 10'd282);
         5'd15: entry_o = ent(1'b0, 4'd13, 10'd282);
         default: entry_o = '0;
      endcase
   end

endmodule

// File: rtl/an_corrector_n29.sv
// Two-stage valid/ready single-error corrector for the A=29 AN code.
// Optional saturating statistics counters are enabled by AN_CORR_STATS_EN.
module an_corrector_n29
   import an29_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [9:0]        in_q,
   input  logic [4:0]        in_r,
   input  logic              in_error,
   input  logic [13:0]       in_receive,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [9:0]        out_data,
   output logic [13:0]       out_codeword,
   output logic [1:0]        out_status,
   output logic [3:0]        out_bitpos,
   output logic              out_sign,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt_corrected,
   output logic [CNT_W-1:0]  cnt_uncorr
);

   localparam int EXT_W = CW_W + 2;
   localparam logic signed [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_CW);

   function automatic logic cw_fits(input logic signed [EXT_W-1:0] x);
      return !x[EXT_W-1] && (x <= MAX_EXT);
   endfunction

   syn_entry_t          ent_d;
   logic                vld_p1_q;
   logic [DATA_W-1:0]   quo_p1_q;
   logic [R_W-1:0]      res_p1_q;
   logic                err_p1_q;
   logic [CW_W-1:0]     rcv_p1_q;
   syn_entry_t          ent_p1_q;

   logic                out_valid_q;
   logic [DATA_W-1:0]   data_p2_q,   data_p2_d;
   logic [CW_W-1:0]     cw_p2_q,     cw_p2_d;
   status_e             status_p2_q, status_p2_d;
   logic [BP_W-1:0]     bp_p2_q,     bp_p2_d;
   logic                sign_p2_q,   sign_p2_d;

   logic                s2_load;
   logic signed [EXT_W-1:0] rcv_ext, pow_ext, cw_ext;

   assign s2_load  = vld_p1_q & (!out_valid_q | out_ready);
   assign in_ready = !vld_p1_q | s2_load;

   // ---- stage 1: syndrome lookup, register lookup result with the word ----
   an29_syndrome_lut u_lut (
      .r_i     (in_r),
      .entry_o (ent_d)
   );

   always_ff @(posedge clk) begin
      if (rst)
         vld_p1_q <= 1'b0;
      else if (in_ready)
         vld_p1_q <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (in_ready & in_valid) begin
         quo_p1_q <= in_q;
         res_p1_q <= in_r;
         err_p1_q <= in_error;
         rcv_p1_q <= in_receive;
         ent_p1_q <= ent_d;
      end
   end

   // ---- stage 2: apply correction, range-check, classify ----
   // One bit wider than the 15-bit signed range so a +2^13 overshoot cannot wrap.
   assign rcv_ext = {2'b00, rcv_p1_q};
   assign pow_ext = {{(EXT_W-1){1'b0}}, 1'b1} << ent_p1_q.bitpos;
   assign cw_ext  = ent_p1_q.sign ? (rcv_ext - pow_ext) : (rcv_ext + pow_ext);

   always_comb begin
      data_p2_d   = quo_p1_q;
      cw_p2_d     = rcv_p1_q;
      status_p2_d = UNCORR;
      bp_p2_d     = '0;
      sign_p2_d   = 1'b0;
      if (err_p1_q == (res_p1_q != '0)) begin
         if (res_p1_q == '0) begin
            status_p2_d = CLEAN;
         end else if (ent_p1_q.valid && cw_fits(cw_ext)) begin
            status_p2_d = CORRECTED;
            cw_p2_d     = cw_ext[CW_W-1:0];
            data_p2_d   = ent_p1_q.sign ? (quo_p1_q - ent_p1_q.k)
                                        : (quo_p1_q + ent_p1_q.k + DATA_W'(1));
            bp_p2_d     = ent_p1_q.bitpos;
            sign_p2_d   = ent_p1_q.sign;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         data_p2_q   <= '0;
         cw_p2_q     <= '0;
         status_p2_q <= CLEAN;
         bp_p2_q     <= '0;
         sign_p2_q   <= 1'b0;
      end else begin
         if (s2_load)
            out_valid_q <= 1'b1;
         else if (out_ready)
            out_valid_q <= 1'b0;
         if (s2_load) begin
            data_p2_q   <= data_p2_d;
            cw_p2_q     <= cw_p2_d;
            status_p2_q <= status_p2_d;
            bp_p2_q     <= bp_p2_d;
            sign_p2_q   <= sign_p2_d;
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = data_p2_q;
   assign out_codeword = cw_p2_q;
   assign out_status   = status_p2_q;
   assign out_bitpos   = bp_p2_q;
   assign out_sign     = sign_p2_q;

   // ---- statistics: count accepted results by status ----
`ifdef AN_CORR_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic [CNT_W-1:0] cnt_corr_q, cnt_unc_q;
   logic             accept;

   assign accept = out_valid_q & out_ready;

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cnt_corr_q <= '0;
         cnt_unc_q  <= '0;
      end else if (accept) begin
         if (status_p2_q == CORRECTED)
            cnt_corr_q <= sat_inc(cnt_corr_q);
         if (status_p2_q == UNCORR)
            cnt_unc_q  <= sat_inc(cnt_unc_q);
      end
   end

   assign cnt_corrected = cnt_corr_q;
   assign cnt_uncorr    = cnt_unc_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign cnt_corrected  = '0;
   assign cnt_uncorr     = '0;
`endif

endmodule

// File: tb/tb_an_corrector_n29.sv
// Randomized and directed bench for an_corrector_n29 with a division-based
// reference model and an output collector; counter checks follow AN_CORR_STATS_EN.
module tb_an_corrector_n29;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef AN_CORR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic [9:0]  d;
      logic [13:0] cw;
      logic [1:0]  st;
      logic [3:0]  bp;
      logic        sg;
   } res_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [9:0]       in_q = '0;
   logic [4:0]       in_r = '0;
   logic             in_error = 1'b0;
   logic [13:0]      in_receive = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [9:0]       out_data;
   logic [13:0]      out_codeword;
   logic [1:0]       out_status;
   logic [3:0]       out_bitpos;
   logic             out_sign;
   logic             cnt_clr = 1'b0;
   logic [CNT_W-1:0] cnt_corrected;
   logic [CNT_W-1:0] cnt_uncorr;

   int   n_pass = 0;
   int   n_total = 0;
   int   exp_corr = 0;
   int   exp_unc = 0;
   int   held_viol = 0;
   int   stall_cnt = 0;
   res_t exp_q[$];
   res_t acc_q[$];

   an_corrector_n29 #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_q(in_q), .in_r(in_r), .in_error(in_error), .in_receive(in_receive),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_codeword(out_codeword), .out_status(out_status),
      .out_bitpos(out_bitpos), .out_sign(out_sign),
      .cnt_clr(cnt_clr), .cnt_corrected(cnt_corrected), .cnt_uncorr(cnt_uncorr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Collector: records accepted results and flags held-output instability.
   initial begin
      res_t snap;
      bit   hold;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
         end else begin
            if (hold && (!out_valid ||
                {out_data, out_codeword, out_status, out_bitpos, out_sign} !== snap))
               held_viol++;
            if (out_valid && out_ready)
               acc_q.push_back({out_data, out_codeword, out_status, out_bitpos, out_sign});
            hold = out_valid && !out_ready;
            snap = {out_data, out_codeword, out_status, out_bitpos, out_sign};
         end
      end
   end

   // Reference: find the single-bit error whose residue matches, undo it, divide by 29.
   function automatic res_t model(input int q, input int r, input int err, input int rcv);
      res_t res;
      int   orig, bi, s, p, m;
      bit   found;
      res = '{d: 10'(q), cw: 14'(rcv), st: 2'b10, bp: 4'd0, sg: 1'b0};
      found = 1'b0;
      orig = 0; bi = 0; s = 0;
      if (r == 0 && err == 0) begin
         res.st = 2'b00;
      end else if (r != 0 && err != 0 && r <= 28) begin
         for (int i = 0; i < 14; i++) begin
            p = 1 << i;
            m = p % 29;
            if (!found && r == m) begin
               found = 1'b1; orig = rcv - p; s = 1; bi = i;
            end else if (!found && r == 29 - m) begin
               found = 1'b1; orig = rcv + p; s = 0; bi = i;
            end
         end
         if (found && orig >= 0 && orig <= 16383) begin
            res.d  = 10'(orig / 29);
            res.cw = 14'(orig);
            res.st = 2'b01;
            res.bp = 4'(bi);
            res.sg = 1'(s);
         end
      end
      return res;
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic int cnt_exp(input int v);
      return STATS ? v : 0;
   endfunction

   task automatic tally();
      foreach (exp_q[i]) begin
         if (exp_q[i].st == 2'b01) exp_corr = sat(exp_corr + 1);
         if (exp_q[i].st == 2'b10) exp_unc  = sat(exp_unc + 1);
      end
   endtask

   // Drives one word; assumes it is called just after a rising edge.
   task automatic push_word(input int q, input int r, input int err, input int rcv);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1; in_q = 10'(q); in_r = 5'(r); in_error = 1'(err); in_receive = 14'(rcv);
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else stall_cnt++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_total++;
      if (!ok) $display("FAIL push_word accept: in_ready=0 for 200 cycles, required 1");
      else n_pass++;
   endtask

   task automatic wait_acc(input int n);
      for (int c = 0; c < 400 && acc_q.size() < n; c++) @(posedge clk);
      n_total++;
      if (acc_q.size() != n)
         $display("FAIL drain count: got %0d results, required %0d", acc_q.size(), n);
      else n_pass++;
   endtask

   task automatic compare_all(input string tag);
      for (int i = 0; i < exp_q.size(); i++) begin
         n_total++;
         if (i >= acc_q.size())
            $display("FAIL %s word %0d: missing, required %h", tag, i, exp_q[i]);
         else if (acc_q[i] !== exp_q[i])
            $display("FAIL %s word %0d: got %h required %h", tag, i, acc_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({out_valid, out_data, out_codeword, out_status, out_bitpos, out_sign} !== '0)
         $display("FAIL reset outputs: got %b/%h/%h/%b/%h/%b required all 0",
                  out_valid, out_data, out_codeword, out_status, out_bitpos, out_sign);
      else n_pass++;
      n_total++;
      if ({cnt_corrected, cnt_uncorr} !== '0)
         $display("FAIL reset counters: got %0d/%0d required 0/0", cnt_corrected, cnt_uncorr);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b required 1", in_ready);
      else n_pass++;
      exp_corr = 0; exp_unc = 0;
   endtask

   task automatic test_latency();
      acc_q.delete(); exp_q.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_q = 10'd100; in_r = 5'd0; in_error = 1'b0; in_receive = 14'd2900;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL latency t+1: out_valid=%b required 0", out_valid);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({out_valid, out_data, out_codeword, out_status} !== {1'b1, 10'd100, 14'd2900, 2'b00})
         $display("FAIL latency t+2: valid=%b data=%0d cw=%0d st=%b required 1/100/2900/00",
                  out_valid, out_data, out_codeword, out_status);
      else n_pass++;
      exp_q.push_back(model(100, 0, 0, 2900));
      wait_acc(1);
      compare_all("latency");
      tally();
   endtask

   task automatic test_directed();
      int   vq[8]  = '{100, 100,   82,   564, 0,   50,  100,  100};
      int   vr[8]  = '{0,   16,    10,   27,  3,   5,   0,    30};
      int   ve[8]  = '{0,   1,     1,    1,   1,   0,   1,    1};
      int   vc[8]  = '{2900, 2916, 2388, 16383, 3, 1455, 2900, 2930};
      res_t vx[8];
      vx[0] = '{d: 10'd100, cw: 14'd2900,  st: 2'b00, bp: 4'd0, sg: 1'b0};
      vx[1] = '{d: 10'd100, cw: 14'd2900,  st: 2'b01, bp: 4'd4, sg: 1'b1};
      vx[2] = '{d: 10'd100, cw: 14'd2900,  st: 2'b01, bp: 4'd9, sg: 1'b0};
      vx[3] = '{d: 10'd564, cw: 14'd16383, st: 2'b10, bp: 4'd0, sg: 1'b0};
      vx[4] = '{d: 10'd0,   cw: 14'd3,     st: 2'b10, bp: 4'd0, sg: 1'b0};
      vx[5] = '{d: 10'd50,  cw: 14'd1455,  st: 2'b10, bp: 4'd0, sg: 1'b0};
      vx[6] = '{d: 10'd100, cw: 14'd2900,  st: 2'b10, bp: 4'd0, sg: 1'b0};
      vx[7] = '{d: 10'd100, cw: 14'd2930,  st: 2'b10, bp: 4'd0, sg: 1'b0};
      acc_q.delete(); exp_q.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(vx[i]);
         push_word(vq[i], vr[i], ve[i], vc[i]);
      end
      wait_acc(8);
      compare_all("directed");
      tally();
      @(negedge clk);
      n_total++;
      if (cnt_corrected !== CNT_W'(cnt_exp(exp_corr)) || cnt_uncorr !== CNT_W'(cnt_exp(exp_unc)))
         $display("FAIL directed counters: got %0d/%0d required %0d/%0d",
                  cnt_corrected, cnt_uncorr, cnt_exp(exp_corr), cnt_exp(exp_unc));
      else n_pass++;
   endtask

   task automatic gen_word(output int q, output int r, output int err, output int rcv);
      int sel;
      rcv = $urandom_range(0, 16383);
      q = rcv / 29; r = rcv % 29; err = (r != 0) ? 1 : 0;
      sel = $urandom_range(0, 15);
      if (sel == 0) err = 1 - err;
      if (sel == 1) begin r = $urandom_range(29, 31); err = 1; end
   endtask

   task automatic test_backpressure();
      int q, r, e, c;
      acc_q.delete(); exp_q.delete();
      held_viol = 0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               gen_word(q, r, e, c);
               exp_q.push_back(model(q, r, e, c));
               push_word(q, r, e, c);
            end
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_acc(8);
      compare_all("backpressure");
      tally();
      n_total++;
      if (held_viol != 0) $display("FAIL held stable: %0d violations, required 0", held_viol);
      else n_pass++;
      acc_q.delete(); exp_q.delete();
      stall_cnt = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         gen_word(q, r, e, c);
         exp_q.push_back(model(q, r, e, c));
         push_word(q, r, e, c);
      end
      n_total++;
      if (stall_cnt != 0) $display("FAIL throughput: %0d stall cycles, required 0", stall_cnt);
      else n_pass++;
      wait_acc(8);
      compare_all("full_rate");
      tally();
   endtask

   task automatic test_random();
      int q, r, e, c;
      bit rdone;
      acc_q.delete(); exp_q.delete();
      held_viol = 0;
      rdone = 1'b0;
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
               gen_word(q, r, e, c);
               exp_q.push_back(model(q, r, e, c));
               push_word(q, r, e, c);
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_acc(150);
      compare_all("random");
      tally();
      n_total++;
      if (held_viol != 0) $display("FAIL random held stable: %0d violations, required 0", held_viol);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (cnt_corrected !== CNT_W'(cnt_exp(exp_corr)) || cnt_uncorr !== CNT_W'(cnt_exp(exp_unc)))
         $display("FAIL random counters: got %0d/%0d required %0d/%0d",
                  cnt_corrected, cnt_uncorr, cnt_exp(exp_corr), cnt_exp(exp_unc));
      else n_pass++;
   endtask

   task automatic test_counters();
      bit seen;
      acc_q.delete(); exp_q.delete();
      out_ready = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      exp_corr = 0; exp_unc = 0;
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back(model(50, 5, 0, 1455));
         push_word(50, 5, 0, 1455);
      end
      wait_acc(20);
      tally();
      @(negedge clk);
      n_total++;
      if (cnt_uncorr !== CNT_W'(cnt_exp(exp_unc)))
         $display("FAIL uncorr saturate: got %0d required %0d", cnt_uncorr, cnt_exp(exp_unc));
      else n_pass++;
      n_total++;
      if (cnt_corrected !== CNT_W'(cnt_exp(exp_corr)))
         $display("FAIL corrected untouched: got %0d required %0d", cnt_corrected, cnt_exp(exp_corr));
      else n_pass++;
      acc_q.delete(); exp_q.delete();
      @(posedge clk); #1 out_ready = 1'b0;
      push_word(50, 5, 0, 1455);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_total++;
      if (!seen) $display("FAIL clr setup: out_valid never rose, required 1");
      else n_pass++;
      @(posedge clk); #1 cnt_clr = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      exp_corr = 0; exp_unc = 0;
      @(negedge clk);
      n_total++;
      if (cnt_uncorr !== '0 || cnt_corrected !== '0)
         $display("FAIL clr priority: got %0d/%0d required 0/0", cnt_corrected, cnt_uncorr);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      acc_q.delete(); exp_q.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(model(100, 16, 1, 2916));
         push_word(100, 16, 1, 2916);
      end
      wait_acc(3);
      compare_all("pre_reset");
      tally();
      @(negedge clk);
      n_total++;
      if (cnt_corrected !== CNT_W'(cnt_exp(exp_corr)))
         $display("FAIL pre-reset count: got %0d required %0d", cnt_corrected, cnt_exp(exp_corr));
      else n_pass++;
      @(posedge clk); #1;
      push_word(100, 16, 1, 2916);
      push_word(82, 10, 1, 2388);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_corr = 0; exp_unc = 0;
      @(negedge clk);
      n_total++;
      if ({out_valid, out_data, out_codeword, out_status, out_bitpos, out_sign} !== '0)
         $display("FAIL midstream reset outputs: valid=%b data=%0d cw=%0d st=%b required all 0",
                  out_valid, out_data, out_codeword, out_status);
      else n_pass++;
      n_total++;
      if ({cnt_corrected, cnt_uncorr} !== '0)
         $display("FAIL midstream reset counters: got %0d/%0d required 0/0", cnt_corrected, cnt_uncorr);
      else n_pass++;
      repeat (5) @(posedge clk);
      n_total++;
      if (acc_q.size() != 3)
         $display("FAIL dropped words: got %0d results, required 3", acc_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_directed();
      test_backpressure();
      test_random();
      test_counters();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
